// File: rtl/sysa_operand_feeder.sv
// Operand feeder for the systolic matrix-multiply array.
// Captures an N-lane x K-element block of A and B operands on start, then
// streams them into the array edge with a diagonal skew: lane i lags lane 0
// by i cycles, one element per lane per cycle. stall freezes the stream.
module sysa_operand_feeder #(
   parameter int DW = 8,
   parameter int N  = 4,
   parameter int K  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stall,
   input  logic [N*K*DW-1:0] a_in,
   input  logic [N*K*DW-1:0] b_in,
   output logic [N*DW-1:0]   a_out,
   output logic [N*DW-1:0]   b_out,
   output logic [N-1:0]      a_vld,
   output logic [N-1:0]      b_vld,
   output logic              busy,
   output logic              done
);

   // Step counter holds the step currently on the outputs; K+N-2 is the last.
   localparam int CW = $clog2(K + N);
   localparam logic [CW-1:0] LAST = CW'(K + N - 2);

   typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     t;
   logic [N*K*DW-1:0] a_cap;
   logic [N*K*DW-1:0] b_cap;

   // Lane i shows element s-i at step s when that element exists, else zero.
   function automatic logic [N*DW-1:0] skew_data(input logic [N*K*DW-1:0] blk,
                                                  input int s);
      logic [N*DW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < K; j++) begin
            if (s == i + j) r[i*DW +: DW] = blk[((i*K)+j)*DW +: DW];
         end
      end
      return r;
   endfunction

   // Lane i is valid at step s while 0 <= s-i < K.
   function automatic logic [N-1:0] skew_vld(input int s);
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         v[i] = (s >= i) && (s < i + K);
      end
      return v;
   endfunction

   // Feed FSM: capture on start, step the skewed stream, pulse done at the end.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         t     <= '0;
         a_cap <= '0;
         b_cap <= '0;
         a_out <= '0;
         b_out <= '0;
         a_vld <= '0;
         b_vld <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               a_out <= '0;
               b_out <= '0;
               a_vld <= '0;
               b_vld <= '0;
               busy  <= 1'b0;
               done  <= 1'b0;
               if (start) begin
                  // Step 0 is presented straight away from the incoming block.
                  a_cap <= a_in;
                  b_cap <= b_in;
                  t     <= '0;
                  a_out <= skew_data(a_in, 0);
                  b_out <= skew_data(b_in, 0);
                  a_vld <= skew_vld(0);
                  b_vld <= skew_vld(0);
                  busy  <= 1'b1;
                  state <= FEED;
               end
            end
            FEED: begin
               if (!stall) begin
                  if (t == LAST) begin
                     t     <= '0;
                     a_out <= '0;
                     b_out <= '0;
                     a_vld <= '0;
                     b_vld <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     t     <= t + CW'(1);
                     a_out <= skew_data(a_cap, int'(t) + 1);
                     b_out <= skew_data(b_cap, int'(t) + 1);
                     a_vld <= skew_vld(int'(t) + 1);
                     b_vld <= skew_vld(int'(t) + 1);
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sysa_operand_feeder.md
# sysa_operand_feeder

Parametrised operand feeder for the systolic matrix-multiply array. It captures an N-lane by K-element block of A operands and of B operands on a start request. It then streams them into the array edge with the diagonal skew the PEs need: lane i is delayed i cycles, one element per lane per cycle. It generalises the fixed 4-element single-stream feeder FSM to configurable width, lane count and depth, and adds start/busy/done handshaking, per-lane valid flags and a stall input.

## Interface
- DW, 8, operand width in bits
- N, 4, lane count (array rows for A, array columns for B); N >= 1
- K, 4, elements per lane (inner dimension); K >= 1
- clk  input  1  single clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request to capture a_in/b_in and begin a feed
- stall  input  1  freeze the feed for this cycle (array back-pressure)
- a_in  input  N*K*DW  A block; lane i, element j at [((i*K)+j)*DW +: DW]
- b_in  input  N*K*DW  B block; same packing as a_in
- a_out  output  N*DW  skewed A stream; lane i at [i*DW +: DW]
- b_out  output  N*DW  skewed B stream; same packing
- a_vld  output  N  per-lane valid for a_out
- b_vld  output  N  per-lane valid for b_out
- busy  output  1  high while in FEED
- done  output  1  one-cycle pulse after the last feed cycle

## Operation
- States: IDLE, FEED, DONE.
- IDLE: outputs zero, busy=0. start=1 latches a_in and b_in into internal registers, clears step counter t, and goes to FEED.
- FEED: busy=1. On each non-stalled cycle, lane i presents element e=t-i when 0 <= e < K, with vld[i]=1. Otherwise the lane presents 0 with vld[i]=0. A and B use identical skew.
- The counter t runs 0 .. K+N-2, a total of K+N-1 feed steps. After step K+N-2, the FSM goes to DONE.
- stall=1 in FEED: t holds, and a_out, b_out and vld hold their previous values. stall is ignored in IDLE and DONE.
- DONE: done=1 for exactly one cycle, outputs zero, busy=0. Returns to IDLE next cycle.
- start while in FEED or DONE is ignored. Captured operands are not disturbed, and a_in/b_in may change freely after capture.
- start is sampled in IDLE only. A start asserted in the DONE cycle is lost; it must be reissued in IDLE.
- Counter width is clog2(K+N) bits and must not wrap within a feed.
- reset_n=0, at any time and asynchronously: state to IDLE, t=0, all outputs 0, captured operand registers cleared. A feed cut short by reset is abandoned; done is not pulsed.

## Timing
- All outputs are registered. None is combinational from inputs.
- Edge E0 samples start=1 in IDLE. During cycle E0..E1, busy=1 and the lane-0 element-0 data plus a_vld[0]=1 are present: the t=0 outputs.
- Lane i element j appears in the cycle beginning at edge E0 + i + j + (stall cycles so far).
- FEED lasts K+N-1 cycles plus stall cycles. done is high in the following cycle, and busy is low during it.
- Minimum start-to-start spacing: K+N+1 cycles (FEED + DONE + IDLE).
- Reset values: a_out=0, b_out=0, a_vld=0, b_vld=0, busy=0, done=0.

## Test plan
- Basic skew (N=4, K=4): a_in lane i element j = 4i+j+1, b_in = a_in+2, start one cycle.
  - a_out lane0 = 1,2,3,4 at t=0..3; lane3 = 13,14,15,16 at t=3..6.
  - b_out is a_out+2 in every valid slot.
  - busy lasts 7 cycles, then done for 1 cycle.
- Valid mask: same run. a_vld per t is 0001, 0011, 0111, 1111, 1110, 1100, 1000 (bit0 = lane0). b_vld is identical. Invalid lanes read 0.
- Stall: stall=1 for 2 cycles at t=2. Outputs and vld hold for those 2 cycles, the sequence then resumes at lane0 = 4, and busy lasts 9 cycles.
- Ignored start and input change: pulse start again at t=3 and change a_in to all 0xFF. The stream is unchanged and done still comes 1 cycle after t=6.
- Reset mid-feed: reset_n=0 at t=4 off the clock edge. All outputs go 0 immediately, no done pulse follows, and a fresh start afterwards produces a correct full stream.
- Degenerate parameters: N=1, K=1, DW=16, a_in=0xBEEF. One feed cycle with a_out=0xBEEF and a_vld=1, then done.
